// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared FSM encoding, op codes and grant-width helper for bram_port_arbiter
package bram_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;
  localparam logic OP_READ = 1'b0;
  localparam logic OP_WRITE = 1'b1;
  function automatic int grant_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin pick (pending, rr in; valid, winner out), first pending at or above rr, else lowest pending
module rr_priority_pick import bram_arb_pkg::*; #(
  parameter int NUM_REQ = 2,
  localparam int GW = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [GW-1:0]      rr,
  output logic               valid,
  output logic [GW-1:0]      winner
);
  logic [NUM_REQ-1:0] upper;
  logic [GW-1:0] w_up, w_any;
  always_comb begin
    upper = '0;
    w_up = '0;
    w_any = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      upper[i] = pending[i] && (i >= int'(rr));
      if (upper[i]) w_up = GW'(i);
      if (pending[i]) w_any = GW'(i);
    end
  end
  assign valid = |pending;
  assign winner = (|upper) ? w_up : w_any;
endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one single-port BRAM (mem_*) among NUM_REQ strobe/op_done requesters (req_*), round-robin, grant_id shows the served port
module bram_port_arbiter import bram_arb_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LATENCY = 1,
  localparam int GW = grant_w(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_wr_en,
  input  logic [NUM_REQ-1:0]          req_rd_en,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_op_done,
  output logic [DATA_W-1:0]           req_rdata,
  output logic [NUM_REQ-1:0]          req_overrun,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [GW-1:0]               grant_id
);
  state_t state;
  logic [NUM_REQ-1:0] pend, slot_op, stb, clr;
  logic [NUM_REQ-1:0][ADDR_W-1:0] slot_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] slot_wdata;
  logic [GW-1:0] rr, pick;
  logic pick_valid;
  logic [2:0] cnt;
  assign stb = req_wr_en | req_rd_en;
  assign clr = (state == DONE) ? NUM_REQ'(1) << grant_id : '0;
  rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .pending(pend),
    .rr(rr),
    .valid(pick_valid),
    .winner(pick)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      slot_op <= '0;
      slot_addr <= '0;
      slot_wdata <= '0;
      req_overrun <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        req_overrun[i] <= stb[i] & pend[i] & ~clr[i];
        if (stb[i] && (!pend[i] || clr[i])) begin
          pend[i] <= 1'b1;
          slot_op[i] <= req_wr_en[i] ? OP_WRITE : OP_READ;
          slot_addr[i] <= req_addr[i*ADDR_W +: ADDR_W];
          slot_wdata[i] <= req_wdata[i*DATA_W +: DATA_W];
        end else if (clr[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr <= '0;
      cnt <= '0;
      grant_id <= '0;
      req_op_done <= '0;
      req_rdata <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      req_op_done <= '0;
      mem_en <= 1'b0;
      case (state)
        IDLE: if (pick_valid) begin
          grant_id <= pick;
          mem_addr <= slot_addr[pick];
          mem_wdata <= slot_wdata[pick];
          mem_we <= slot_op[pick] == OP_WRITE;
          mem_en <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: if (mem_we) begin
          req_op_done[grant_id] <= 1'b1;
          state <= DONE;
        end else begin
          cnt <= 3'(RD_LATENCY - 1);
          state <= WAIT_RD;
        end
        WAIT_RD: if (cnt == 3'd0) begin
          req_rdata <= mem_rdata;
          req_op_done[grant_id] <= 1'b1;
          state <= DONE;
        end else begin
          cnt <= cnt - 3'd1;
        end
        DONE: begin
          rr <= (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one single-port BRAM between NUM_REQ memory-controller-style requesters; each requester sees a private BRAM port: one-cycle rd/wr strobe in, op_done pulse back.
- Sits between per-clock-domain controllers (already in the 65 MHz domain) and the BRAM primitive.
- Captures strobes into per-requester pending slots, grants round-robin, sequences BRAM enable/read latency, returns read data plus op_done.

Parameters:
- NUM_REQ, 2, number of requester ports (2..8)
- ADDR_W, 8, BRAM address width
- DATA_W, 8, BRAM data width
- RD_LATENCY, 1, BRAM read latency in cycles, measured from mem_en to valid mem_rdata (1..4)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req_wr_en  in  NUM_REQ  per-requester one-cycle write strobe
- req_rd_en  in  NUM_REQ  per-requester one-cycle read strobe
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing
- req_op_done  out  NUM_REQ  one-cycle completion pulse per requester
- req_rdata  out  DATA_W  shared read-data return, qualified by req_op_done of a read
- req_overrun  out  NUM_REQ  one-cycle pulse: strobe dropped because that slot was already pending
- mem_en  out  1  BRAM enable
- mem_we  out  1  BRAM write enable, qualified by mem_en
- mem_addr  out  ADDR_W  BRAM address
- mem_wdata  out  DATA_W  BRAM write data
- mem_rdata  in  DATA_W  BRAM read data
- grant_id  out  clog2(NUM_REQ), min 1  index of the requester being served; holds its last value

Behaviour:
- Reset (async, rst=1): all outputs 0; pending slots cleared; rr pointer = 0; FSM = IDLE. Reset mid-operation discards all pending and in-flight ops; no op_done is issued for them.
- Capture: at the edge where req_wr_en[i] or req_rd_en[i] is 1 and slot i is empty, slot i latches op, addr[i] and wdata[i].
  - If both strobes are 1, the op is a write.
  - If slot i is already pending, the strobe is dropped, the slot is unchanged, and req_overrun[i] pulses the next cycle.
  - Exception: slot i being cleared in DONE this cycle counts as empty, so set wins over clear.
- FSM states: IDLE, ISSUE, WAIT_RD, DONE. All outputs are registered.
  - IDLE: if any slot is pending, pick a winner round-robin starting at rr pointer; load mem_addr/mem_wdata/mem_we and grant_id; go to ISSUE.
  - ISSUE: mem_en=1 for exactly this cycle. Write: go to DONE. Read: load latency counter, go to WAIT_RD.
  - WAIT_RD: stay RD_LATENCY cycles; on the last cycle latch mem_rdata into req_rdata; go to DONE.
  - DONE: req_op_done[grant]=1; clear the winning slot; rr pointer = grant+1, wrapping at NUM_REQ; go to IDLE.
- Latency, strobe at cycle T:
  - Slot pending at T+1; mem_en at T+2.
  - Write: op_done at T+3.
  - Read: op_done at T+3+RD_LATENCY.
  - Best-case throughput: one write per 3 cycles.
- req_rdata is valid in the op_done cycle and holds until the next read completes. Writes do not change req_rdata.
- mem_addr, mem_wdata and mem_we hold their values outside ISSUE; only mem_en qualifies them.
- Fairness: a continuously requesting port waits at most NUM_REQ-1 other operations.

Decomposition:
- Package bram_arb_pkg: FSM state encoding, OP_READ/OP_WRITE constants, helper for GRANT_W = max(1, clog2(NUM_REQ)).
- Sub-module rr_priority_pick: inputs pending vector and rr pointer; outputs valid and winner index. It is combinational and parameterised by NUM_REQ.
- Top level holds the slot registers, FSM and latency counter.

Test Plan:
- Single write: req_wr_en[0] at T, addr 0x3C, wdata 0xA5 -> mem_en=1, mem_we=1, mem_addr=0x3C, mem_wdata=0xA5 at T+2; req_op_done[0] at T+3.
- Single read after that write: req_rd_en[1] addr 0x3C at T, RD_LATENCY=1 -> mem_en=1, mem_we=0 at T+2; req_op_done[1]=1 and req_rdata=0xA5 at T+4.
- Simultaneous strobes: req_wr_en[0] (0x10←0x11) and req_wr_en[1] (0x20←0x22) at T, rr=0 -> port 0 served first (op_done[0] at T+3), port 1 next (mem_en at T+5, op_done[1] at T+6); rr pointer ends at 0.
- Fairness: both ports re-strobe on every op_done for 20 ops -> grants strictly alternate 0,1,0,1; no overrun.
- Overrun: req_rd_en[0] at T and again at T+1 -> req_overrun[0] at T+2; exactly one op_done[0]; the first request's address is used.
- Reset mid-read, and RD_LATENCY=3:
  - rst asserted during WAIT_RD -> all outputs 0 immediately; no op_done follows; the next request completes normally.
  - RD_LATENCY=3 -> read op_done at T+6.
